// File: rtl/bus_slave_resp.sv
// Slave-side bus responder: serves selected accesses from a small word store
// after WAIT_CYC wait states and answers with a one-cycle active-low ready.
`timescale 1ns/1ps
module bus_slave_resp #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        s_cs_,
  input  logic [29:0] s_addr,
  input  logic        s_as_,
  input  logic        s_rw,
  input  logic [31:0] s_wr_data,
  output logic [31:0] s_rd_data,
  output logic        s_rdy_
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   idx;
  logic               rw;
  logic [31:0]        wr_data_l;
  logic [31:0]        mem [DEPTH];
  logic [IDX_W-1:0]   rd_idx;
  logic               unused_addr;

  // Upper address bits alias onto the same words; they are deliberately dropped.
  assign unused_addr = ^s_addr[29:IDX_W];

  // With zero wait states ACK is entered straight from IDLE, so read the live index.
  assign rd_idx = (state == IDLE) ? s_addr[IDX_W-1:0] : idx;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      rw        <= 1'b0;
      wr_data_l <= '0;
      s_rdy_    <= 1'b1;
      s_rd_data <= '0;
    end else begin
      s_rdy_    <= 1'b1;
      s_rd_data <= '0;
      case (state)
        IDLE: begin
          if (!s_cs_ && !s_as_) begin
            idx       <= s_addr[IDX_W-1:0];
            rw        <= s_rw;
            wr_data_l <= s_wr_data;
            if (WAIT_CYC == 0) begin
              state     <= ACK;
              s_rdy_    <= 1'b0;
              s_rd_data <= s_rw ? mem[rd_idx] : '0;
            end else begin
              cnt   <= 4'(WAIT_CYC - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (s_as_ || s_cs_) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state     <= ACK;
            s_rdy_    <= 1'b0;
            s_rd_data <= rw ? mem[rd_idx] : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write commits on the edge leaving ACK, so the next access already sees it.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == ACK && !rw) begin
      mem[idx] <= wr_data_l;
    end
  end

endmodule

// File: tb/tb_bus_slave_resp.sv
// Self-checking bench for bus_slave_resp: five instances with different wait-state
// counts share one bus, each selected by its own chip select.
`timescale 1ns/1ps
module tb_bus_slave_resp;

  localparam int NDUT = 5;
  localparam logic [NDUT-1:0][3:0] WCS = {4'd15, 4'd3, 4'd2, 4'd1, 4'd0};

  logic        clk = 1'b0;
  logic        reset_;
  logic [29:0] s_addr;
  logic        s_as_;
  logic        s_rw;
  logic [31:0] s_wr_data;
  logic        cs_sel  [NDUT];
  logic [31:0] rd_data [NDUT];
  logic        rdy     [NDUT];

  typedef struct {
    int          lat;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [NDUT][16];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    bus_slave_resp #(
      .DEPTH   (16),
      .IDX_W   (4),
      .WAIT_CYC(int'(WCS[gi]))
    ) u_dut (
      .clk      (clk),
      .reset_   (reset_),
      .s_cs_    (cs_sel[gi]),
      .s_addr   (s_addr),
      .s_as_    (s_as_),
      .s_rw     (s_rw),
      .s_wr_data(s_wr_data),
      .s_rd_data(rd_data[gi]),
      .s_rdy_   (rdy[gi])
    );
  end

  function automatic int wcyc(input int k);
    return int'(WCS[k]);
  endfunction

  task automatic release_bus();
    s_as_ = 1'b1;
    for (int i = 0; i < NDUT; i++) cs_sel[i] = 1'b1;
  endtask

  // One access on dut k; expectation queued at drive time, popped at ready.
  task automatic do_access(input int k, input logic [29:0] addr, input logic rw,
                           input logic [31:0] wdata);
    exp_t e;
    int   n;
    bit   seen;
    e.lat  = wcyc(k) + 1;
    e.data = rw ? model[k][addr[3:0]] : 32'h0;
    sb.push_back(e);
    @(negedge clk);
    cs_sel[k] = 1'b0; s_as_ = 1'b0; s_addr = addr; s_rw = rw; s_wr_data = wdata;
    @(posedge clk);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[k] === 1'b0) seen = 1'b1;
    end
    e = sb.pop_front();
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL access_timeout dut%0d addr=%h: no ready in %0d cycles, required at %0d", k, addr, n, e.lat);
    end else begin
      if (n !== e.lat) begin
        miscompares++;
        $display("FAIL latency dut%0d addr=%h: got %0d cycles, required %0d", k, addr, n, e.lat);
      end
      vectors++;
      if (rd_data[k] !== e.data) begin
        miscompares++;
        $display("FAIL rd_data dut%0d addr=%h rw=%0d: got %h, required %h", k, addr, rw, rd_data[k], e.data);
      end
      if (!rw) model[k][addr[3:0]] = wdata;
    end
    release_bus();
    @(negedge clk);
    vectors++;
    if (rdy[k] !== 1'b1 || rd_data[k] !== 32'h0) begin
      miscompares++;
      $display("FAIL pulse_width dut%0d: rdy=%b rd_data=%h, required rdy=1 rd_data=0", k, rdy[k], rd_data[k]);
    end
    $display("access dut%0d wait=%0d rw=%0d addr=%h wdata=%h rdata=%h lat=%0d", k, wcyc(k), rw, addr, wdata, rd_data[k], n);
  endtask

  task automatic check_quiet(input string name, input int cycles);
    bit bad = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (rdy[k] !== 1'b1 || rd_data[k] !== 32'h0) bad = 1'b1;
      end
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: unexpected ready/data activity, required rdy=1 rd_data=0 on all slaves", name);
    end
    $display("quiet check %s over %0d cycles", name, cycles);
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    release_bus();
    s_addr = '0; s_rw = 1'b1; s_wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      vectors++;
      if (rdy[k] !== 1'b1 || rd_data[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: rdy=%b rd_data=%h, required 1/00000000", k, rdy[k], rd_data[k]);
      end
      for (int a = 0; a < 16; a++) model[k][a] = 32'h0;
    end
    reset_ = 1'b1;
    $display("reset released");
  endtask

  task automatic test_reset_read();
    do_access(1, 30'h5, 1'b1, 32'h0);
  endtask

  task automatic test_write_read();
    do_access(1, 30'h3, 1'b0, 32'hDEADBEEF);
    do_access(1, 30'h3, 1'b1, 32'h0);
    do_access(1, 30'h13, 1'b1, 32'h0);
    do_access(1, 30'h3FFFFFF9, 1'b0, 32'h600DCAFE);
    do_access(1, 30'h9, 1'b1, 32'h0);
  endtask

  task automatic test_wait_sweep();
    int ks [3] = '{0, 3, 4};
    for (int i = 0; i < 3; i++) begin
      do_access(ks[i], 30'(i + 10), 1'b0, 32'hC0DE0000 | 32'(i));
      do_access(ks[i], 30'(i + 10), 1'b1, 32'h0);
    end
  endtask

  task automatic test_abort();
    do_access(3, 30'h7, 1'b0, 32'h0BADF00D);
    @(negedge clk);
    cs_sel[3] = 1'b0; s_as_ = 1'b0; s_addr = 30'h7; s_rw = 1'b0; s_wr_data = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    release_bus();
    check_quiet("abort_no_ready", 20);
    do_access(3, 30'h7, 1'b1, 32'h0);
  endtask

  task automatic test_unselected();
    @(negedge clk);
    s_as_ = 1'b0; s_rw = 1'b0; s_addr = 30'h3; s_wr_data = 32'hFFFFFFFF;
    check_quiet("unselected_strobe", 5);
    release_bus();
    do_access(1, 30'h3, 1'b1, 32'h0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    int   hits;
    int   w = wcyc(1);
    e.data = model[1][3];
    e.lat  = w + 1;
    sb.push_back(e);
    e.lat  = 2 * w + 3;
    sb.push_back(e);
    @(negedge clk);
    cs_sel[1] = 1'b0; s_as_ = 1'b0; s_addr = 30'h3; s_rw = 1'b1;
    @(posedge clk);
    n = 0; hits = 0;
    while (hits < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (rdy[1] === 1'b0) begin
        e = sb.pop_front();
        hits++;
        vectors++;
        if (n !== e.lat || rd_data[1] !== e.data) begin
          miscompares++;
          $display("FAIL back_to_back ack%0d: cycle %0d data %h, required cycle %0d data %h", hits, n, rd_data[1], e.lat, e.data);
        end
        $display("held strobe ack%0d at cycle %0d data=%h", hits, n, rd_data[1]);
        if (hits == 2) release_bus();
      end
    end
    if (hits < 2) begin
      while (sb.size() > 0) e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL back_to_back_timeout: %0d acks seen, required 2", hits);
      release_bus();
    end
    check_quiet("after_back_to_back", 4);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cs_sel[2] = 1'b0; s_as_ = 1'b0; s_addr = 30'h2; s_rw = 1'b0; s_wr_data = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    reset_ = 1'b0;
    @(negedge clk);
    release_bus();
    @(negedge clk);
    reset_ = 1'b1;
    for (int k = 0; k < NDUT; k++)
      for (int a = 0; a < 16; a++) model[k][a] = 32'h0;
    check_quiet("reset_mid_no_ready", 6);
    do_access(2, 30'h2, 1'b1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_reset_read();
    test_write_read();
    test_wait_sweep();
    test_abort();
    test_unselected();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
